// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic [3:0] rd;
  } mw_ctrl_t;

  localparam int MW_CTRL_W = 7;
  localparam int MW_DATA_W = 64;

  // Entry count held by the stage in each state.
  function automatic logic [1:0] state_occupancy(input skid_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer and flush.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = MW_CTRL_W,
  parameter int DATA_W = MW_DATA_W
`ifdef PIPE_STAGE_STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output skid_state_t       dbg_state,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; the producer holds valid and payload stable until then. Both ready
  // and valid come straight from state_q, so nothing combinational crosses.
  skid_state_t       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign occupancy = state_occupancy(state_q);
  assign dbg_state = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Slots keep their bits so out_data holds; EMPTY marks them invalid.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Bubbles carry all-zero control so no write enable leaks downstream.
  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  assign out_data = main_data_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .clear_i(~reset),
    .inc_i  (out_valid & ~out_ready),
    .cnt_o  (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a queue-based reference model.
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_ctrl;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_ctrl;
  logic [63:0] out_data;
  logic [1:0]  dbg_state;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [70:0] exp_q[$];
  logic [63:0] shown_data;
  logic [31:0] stall_model;

  localparam logic [63:0] DA = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] DB = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] DC = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] DD = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] DE = 64'hEEEE_0000_0000_0005;

  pipe_stage_skid dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .dbg_state(dbg_state),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs, cross one rising edge, update the model, compare.
  task automatic cycle(input logic rst_n, input logic fl, input logic iv,
                       input logic [6:0] c, input logic [63:0] d, input logic ordy);
    logic        m_in_fire;
    logic        m_out_fire;
    logic        m_stall;
    logic [70:0] head;
    logic [6:0]  exp_ctrl;
    int          sz;
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    m_in_fire  = iv && (exp_q.size() < 2);
    m_out_fire = (exp_q.size() > 0) && ordy;
    m_stall    = (exp_q.size() > 0) && !ordy;
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      shown_data  = '0;
      stall_model = '0;
    end else begin
      if (m_stall && stall_model != 32'hFFFF_FFFF) stall_model = stall_model + 1;
      if (m_out_fire) void'(exp_q.pop_front());
      if (fl) exp_q.delete();
      else if (m_in_fire) exp_q.push_back({c, d});
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        shown_data = head[63:0];
      end
    end
    sz = exp_q.size();
    exp_ctrl = 7'd0;
    if (sz > 0) begin
      head = exp_q[0];
      exp_ctrl = head[70:64];
    end
    check("out_valid", 64'(out_valid), 64'(sz > 0));
    check("in_ready", 64'(in_ready), 64'(sz < 2));
    check("occupancy", 64'(occupancy), 64'(sz));
    check("dbg_state", 64'(dbg_state), 64'(sz));
    check("out_ctrl", 64'(out_ctrl), 64'(exp_ctrl));
    check("out_data", out_data, shown_data);
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    shown_data = '0; stall_model = '0;

    // Reset held two cycles with in_valid high: nothing captured.
    cycle(1'b0, 1'b0, 1'b1, 7'h15, DD, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 7'h15, DD, 1'b0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);

    // Streaming with out_ready held high.
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DA, 1'b1);
    check("stream_a", out_data, DA);
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DB, 1'b1);
    check("stream_b", out_data, DB);
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DC, 1'b1);
    check("stream_c", out_data, DC);
    check("stream_occ", 64'(occupancy), 64'd1);
    // Drain: bubble has zero ctrl while payload is retained.
    cycle(1'b1, 1'b0, 1'b0, 7'h00, '0, 1'b1);
    check("bubble_ctrl", 64'(out_ctrl), 64'd0);
    check("bubble_data", out_data, DC);

    // Backpressure fills the skid slot.
    cycle(1'b1, 1'b0, 1'b1, 7'h2A, DA, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DB, 1'b0);
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_hold_a", out_data, DA);
    check("bp_ctrl_a", 64'(out_ctrl), 64'h2A);
    cycle(1'b1, 1'b0, 1'b1, 7'h33, DC, 1'b1);
    check("bp_then_b", out_data, DB);
    cycle(1'b1, 1'b0, 1'b1, 7'h33, DC, 1'b1);
    check("bp_then_c", out_data, DC);
    check("bp_ctrl_c", 64'(out_ctrl), 64'h33);
    cycle(1'b1, 1'b0, 1'b0, 7'h00, '0, 1'b1);

    // Flush from FULL with D offered: D must never show.
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DA, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DB, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 7'h7F, DD, 1'b0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    cycle(1'b1, 1'b0, 1'b0, 7'h00, '0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 7'h00, '0, 1'b1);

    // Flush from BUSY with a same-cycle in_fire and out_fire.
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DA, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 7'h15, DE, 1'b1);
    check("flush2_occ", 64'(occupancy), 64'd0);
    cycle(1'b1, 1'b0, 1'b1, 7'h0C, DE, 1'b1);
    check("after_flush_e", out_data, DE);
    cycle(1'b1, 1'b0, 1'b0, 7'h00, '0, 1'b1);

    // Reset mid-transfer discards stored entries.
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DA, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DB, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 7'h00, '0, 1'b0);
    check("midrst_data", out_data, 64'd0);

    // Stall window: five stalled cycles, then flush, then reset.
    cycle(1'b1, 1'b0, 1'b1, 7'h15, DA, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 7'h00, '0, 1'b0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("stall_5", 64'(stall_cnt), 64'd5);
`endif
    cycle(1'b1, 1'b1, 1'b0, 7'h00, '0, 1'b1);
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("stall_flush", 64'(stall_cnt), 64'd5);
`endif
    cycle(1'b0, 1'b0, 1'b0, 7'h00, '0, 1'b0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("stall_rst", 64'(stall_cnt), 64'd0);
`endif

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
